// File: rtl/mem_arb_pkg.sv
// Purpose : shared types and limits for the two-port memory arbiter.
// Latency : n/a (types only).
// Backpressure : n/a (types only).
package mem_arb_pkg;

  // Arbiter FSM: IDLE accepts one request, WAIT holds off until its response.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  // Identity of a requester; also used as the last-grant pointer.
  typedef enum logic [0:0] {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  // Deepest memory read latency the 2-bit latency counter can time.
  localparam int MEM_LAT_MAX = 4;
  localparam int LAT_CNT_W   = 2;

endpackage

// File: rtl/mem_arbiter.sv
// Purpose : arbitrates an instruction-fetch port and a load/store port onto one
//           shared single-ported memory, one outstanding access at a time.
// Latency : grant is combinational in IDLE; the response (rvalid) arrives
//           MEM_LAT cycles after the grant, and the next grant can follow one
//           cycle after rvalid (1 access per MEM_LAT+1 cycles).
// Backpressure : requesters hold req until gnt; no gnt is given while an access
//           is outstanding, and ties in IDLE are broken round-robin.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   if_req/if_addr           fetch request in; if_gnt/if_rvalid/if_rdata out
//   ls_req/ls_we/ls_addr/
//   ls_wdata/ls_wstrb        load/store request in; ls_gnt/ls_rvalid/ls_rdata out
//   mem_en/mem_we/mem_addr/
//   mem_wdata/mem_wstrb      memory command out (valid only while mem_en=1)
//   mem_rdata                memory read data, valid MEM_LAT cycles after mem_en
//   busy                     high while an access is outstanding
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  // fetch port
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  // load/store port
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic [3:0]  ls_wstrb,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  // shared memory
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  // status
  output logic        busy
);

  // Keep the counter load inside what a 2-bit counter can represent.
  localparam int LAT_EFF = (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX :
                           ((MEM_LAT < 1) ? 1 : MEM_LAT);
  localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(LAT_EFF - 1);

  state_e                r_state;
  logic [LAT_CNT_W-1:0]  r_lat_cnt;
  owner_e                r_owner;
  logic                  r_we;
  owner_e                r_last;

  logic w_idle;
  logic w_gnt_if;
  logic w_gnt_ls;
  logic w_gnt;
  logic w_done;

  // Outputs are forced low while rst is held, so gating on !rst here keeps a
  // request that is already high during reset from leaking a grant.
  assign w_idle = (r_state == IDLE) && !rst;

  // Round-robin tie break: on a collision the side that did not win last time
  // takes the grant. A lone request always wins.
  assign w_gnt_if = w_idle && if_req && (!ls_req || (r_last == OWN_LS));
  assign w_gnt_ls = w_idle && ls_req && (!if_req || (r_last == OWN_IF));
  assign w_gnt    = w_gnt_if || w_gnt_ls;

  // Final cycle of an access: memory data is valid now.
  assign w_done = (r_state == WAIT) && (r_lat_cnt == '0) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_lat_cnt <= '0;
      r_owner   <= OWN_IF;
      r_we      <= 1'b0;
      r_last    <= OWN_LS;  // so the first tie after reset goes to fetch
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt) begin
            r_state   <= WAIT;
            r_lat_cnt <= LAT_INIT;
            r_owner   <= w_gnt_ls ? OWN_LS : OWN_IF;
            r_last    <= w_gnt_ls ? OWN_LS : OWN_IF;
            // Fetch never writes, so only a load/store grant can set the flag.
            r_we      <= w_gnt_ls && ls_we;
          end
        end
        WAIT: begin
          if (r_lat_cnt == '0) begin
            r_state <= IDLE;
          end else begin
            r_lat_cnt <= r_lat_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Memory command mux: everything is zero unless a grant is being issued.
  always_comb begin
    mem_en    = w_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (w_gnt_if) begin
      mem_addr = if_addr;
    end else if (w_gnt_ls) begin
      mem_we    = ls_we;
      mem_addr  = ls_addr;
      mem_wdata = ls_wdata;
      mem_wstrb = ls_wstrb;
    end
  end

  // Response routing uses the owner and write flag captured at grant time;
  // the requester inputs are not looked at during WAIT.
  always_comb begin
    if_rvalid = w_done && (r_owner == OWN_IF);
    ls_rvalid = w_done && (r_owner == OWN_LS);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    // A store acknowledge carries no data.
    ls_rdata  = (ls_rvalid && !r_we) ? mem_rdata : '0;
  end

  assign if_gnt = w_gnt_if;
  assign ls_gnt = w_gnt_ls;
  assign busy   = (r_state == WAIT) && !rst;

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose : directed self-checking bench for mem_arbiter at MEM_LAT=1 and 3.
// Latency : n/a.
// Backpressure : n/a.
module tb_mem_arbiter;

  typedef struct packed {
    logic        if_req;
    logic [31:0] if_addr;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_wstrb;
    logic [31:0] mem_rdata;
  } in_t;

  typedef struct packed {
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        busy;
  } out_t;

  typedef struct {
    in_t  in;
    out_t exp_gnt;   // outputs in the grant cycle
    out_t exp_rsp;   // outputs in the following (response) cycle
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  in_t  i1, i3;
  out_t o1, o3;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst),
    .if_req(i1.if_req), .if_addr(i1.if_addr),
    .if_gnt(o1.if_gnt), .if_rvalid(o1.if_rvalid), .if_rdata(o1.if_rdata),
    .ls_req(i1.ls_req), .ls_we(i1.ls_we), .ls_addr(i1.ls_addr),
    .ls_wdata(i1.ls_wdata), .ls_wstrb(i1.ls_wstrb),
    .ls_gnt(o1.ls_gnt), .ls_rvalid(o1.ls_rvalid), .ls_rdata(o1.ls_rdata),
    .mem_en(o1.mem_en), .mem_we(o1.mem_we), .mem_addr(o1.mem_addr),
    .mem_wdata(o1.mem_wdata), .mem_wstrb(o1.mem_wstrb),
    .mem_rdata(i1.mem_rdata), .busy(o1.busy)
  );

  mem_arbiter #(.MEM_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst),
    .if_req(i3.if_req), .if_addr(i3.if_addr),
    .if_gnt(o3.if_gnt), .if_rvalid(o3.if_rvalid), .if_rdata(o3.if_rdata),
    .ls_req(i3.ls_req), .ls_we(i3.ls_we), .ls_addr(i3.ls_addr),
    .ls_wdata(i3.ls_wdata), .ls_wstrb(i3.ls_wstrb),
    .ls_gnt(o3.ls_gnt), .ls_rvalid(o3.ls_rvalid), .ls_rdata(o3.ls_rdata),
    .mem_en(o3.mem_en), .mem_we(o3.mem_we), .mem_addr(o3.mem_addr),
    .mem_wdata(o3.mem_wdata), .mem_wstrb(o3.mem_wstrb),
    .mem_rdata(i3.mem_rdata), .busy(o3.busy)
  );

  function automatic in_t mi(input logic ir, input logic [31:0] ia,
                             input logic lr, input logic lw,
                             input logic [31:0] la, input logic [31:0] wd,
                             input logic [3:0] ws, input logic [31:0] rd);
    in_t r;
    r.if_req = ir;  r.if_addr = ia;
    r.ls_req = lr;  r.ls_we = lw; r.ls_addr = la;
    r.ls_wdata = wd; r.ls_wstrb = ws; r.mem_rdata = rd;
    return r;
  endfunction

  function automatic out_t mo(input logic ig, input logic lg, input logic en,
                              input logic we, input logic [31:0] ad,
                              input logic [31:0] wd, input logic [3:0] ws,
                              input logic irv, input logic lrv,
                              input logic [31:0] ird, input logic [31:0] lrd,
                              input logic bsy);
    out_t r;
    r.if_gnt = ig; r.ls_gnt = lg; r.mem_en = en; r.mem_we = we;
    r.mem_addr = ad; r.mem_wdata = wd; r.mem_wstrb = ws;
    r.if_rvalid = irv; r.ls_rvalid = lrv; r.if_rdata = ird; r.ls_rdata = lrd;
    r.busy = bsy;
    return r;
  endfunction

  // Whole-output comparison; rdata is only compared where rvalid is expected
  // unless strict is set.
  task automatic chk(input string name, input out_t act, input out_t exp,
                     input bit strict);
    out_t a, e;
    a = act;
    e = exp;
    if (!strict) begin
      if (!e.if_rvalid) begin a.if_rdata = '0; e.if_rdata = '0; end
      if (!e.ls_rvalid) begin a.ls_rdata = '0; e.ls_rdata = '0; end
    end
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask

  task automatic chk1(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    i1 = '0;
    i3 = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Both requests held from reset: grants must alternate IF, LS, IF, LS with
  // a fixed spacing of MEM_LAT+1 cycles.
  task automatic alternate(input bit use3, input int gap);
    int   last_c;
    int   n;
    logic exp_if;
    out_t o;
    last_c = 0;
    n = 0;
    exp_if = 1'b1;
    do_reset();
    if (use3) begin i3.if_req = 1'b1; i3.ls_req = 1'b1; end
    else      begin i1.if_req = 1'b1; i1.ls_req = 1'b1; end
    for (int c = 0; c < 40 && n < 4; c++) begin
      #1;
      o = use3 ? o3 : o1;
      if (o.if_gnt || o.ls_gnt) begin
        chk1(use3 ? "alt3_owner" : "alt1_owner", {31'd0, o.if_gnt},
             {31'd0, exp_if});
        if (n == 0) chk1(use3 ? "alt3_first" : "alt1_first", c, 0);
        else        chk1(use3 ? "alt3_gap" : "alt1_gap", c - last_c, gap);
        exp_if = !exp_if;
        last_c = c;
        n++;
      end
      @(negedge clk);
    end
    chk1(use3 ? "alt3_count" : "alt1_count", n, 4);
    i1 = '0;
    i3 = '0;
  endtask

  vec_t vecs[8];

  initial begin
    int   rv_cnt;

    // Directed table for MEM_LAT=1; the last-grant pointer carries between
    // entries (reset leaves it at LS, so the first tie goes to IF).
    // v0: fetch only, addr 0x10
    vecs[0].in      = mi(1, 32'h10, 0, 0, 0, 0, 0, 32'h1111_1111);
    vecs[0].exp_gnt = mo(1, 0, 1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0);
    vecs[0].exp_rsp = mo(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h1111_1111, 0, 1);
    // v1: load only
    vecs[1].in      = mi(0, 0, 1, 0, 32'h40, 0, 0, 32'h2222_2222);
    vecs[1].exp_gnt = mo(0, 1, 1, 0, 32'h40, 0, 0, 0, 0, 0, 0, 0);
    vecs[1].exp_rsp = mo(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h2222_2222, 1);
    // v2: store 0xDEADBEEF to 0x20, all bytes; ack carries rdata 0
    vecs[2].in      = mi(0, 0, 1, 1, 32'h20, 32'hDEAD_BEEF, 4'hF, 32'h3333_3333);
    vecs[2].exp_gnt = mo(0, 1, 1, 1, 32'h20, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0);
    vecs[2].exp_rsp = mo(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, 1);
    // v3: fetch alone with store-looking LS inputs (no ls_req), unaligned addr
    vecs[3].in      = mi(1, 32'h1233, 0, 1, 32'h99, 32'h55, 4'hF, 32'h4444_4444);
    vecs[3].exp_gnt = mo(1, 0, 1, 0, 32'h1233, 0, 0, 0, 0, 0, 0, 0);
    vecs[3].exp_rsp = mo(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h4444_4444, 0, 1);
    // v4: tie after an IF grant -> LS store wins
    vecs[4].in      = mi(1, 32'h80, 1, 1, 32'h44, 32'hCAFE_0001, 4'h5, 32'hAAAA_AAAA);
    vecs[4].exp_gnt = mo(0, 1, 1, 1, 32'h44, 32'hCAFE_0001, 4'h5, 0, 0, 0, 0, 0);
    vecs[4].exp_rsp = mo(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, 1);
    // v5: tie after an LS grant -> IF wins
    vecs[5].in      = mi(1, 32'h80, 1, 0, 32'h48, 0, 0, 32'hBBBB_BBBB);
    vecs[5].exp_gnt = mo(1, 0, 1, 0, 32'h80, 0, 0, 0, 0, 0, 0, 0);
    vecs[5].exp_rsp = mo(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hBBBB_BBBB, 0, 1);
    // v6: no requests -> bus idle, nothing comes back
    vecs[6].in      = mi(0, 32'h500, 0, 1, 32'h600, 32'h77, 4'hF, 32'hCCCC_CCCC);
    vecs[6].exp_gnt = mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[6].exp_rsp = mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // v7: tie, last winner still IF (idle cycle does not move it) -> LS load
    vecs[7].in      = mi(1, 32'h84, 1, 0, 32'h100, 0, 0, 32'h0000_0077);
    vecs[7].exp_gnt = mo(0, 1, 1, 0, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    vecs[7].exp_rsp = mo(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0000_0077, 1);

    // Reset state with requests already high: every output must be 0.
    rst = 1'b1;
    i1 = '0;
    i3 = '0;
    i1.if_req = 1'b1; i1.ls_req = 1'b1; i1.if_addr = 32'h10;
    i3.if_req = 1'b1; i3.ls_req = 1'b1; i3.if_addr = 32'h10;
    #2;
    chk("reset_lat1", o1, '0, 1'b1);
    chk("reset_lat3", o3, '0, 1'b1);

    do_reset();
    foreach (vecs[k]) begin
      i1 = vecs[k].in;
      #1;
      chk($sformatf("vec%0d_gnt", k), o1, vecs[k].exp_gnt, 1'b0);
      @(negedge clk);
      i1.if_req = 1'b0;
      i1.ls_req = 1'b0;
      #1;
      chk($sformatf("vec%0d_rsp", k), o1, vecs[k].exp_rsp, 1'b0);
      @(negedge clk);
    end
    i1 = '0;

    alternate(1'b0, 2);
    alternate(1'b1, 4);

    // Fetch raised during an LS load's WAIT (MEM_LAT=3): held off until the
    // cycle after ls_rvalid.
    do_reset();
    i3.ls_req = 1'b1; i3.ls_addr = 32'h200; i3.mem_rdata = 32'h5A5A_5A5A;
    #1;
    chk1("blk_ls_gnt", {31'd0, o3.ls_gnt}, 32'd1);
    @(negedge clk);
    i3.ls_req = 1'b0;
    i3.if_req = 1'b1; i3.if_addr = 32'h300;
    for (int k = 1; k <= 3; k++) begin
      #1;
      chk1($sformatf("blk_if_gnt_c%0d", k), {31'd0, o3.if_gnt}, 32'd0);
      chk1($sformatf("blk_ls_rvalid_c%0d", k), {31'd0, o3.ls_rvalid},
           (k == 3) ? 32'd1 : 32'd0);
      if (k == 3) chk1("blk_ls_rdata", o3.ls_rdata, 32'h5A5A_5A5A);
      @(negedge clk);
    end
    #1;
    chk1("blk_if_gnt_after", {31'd0, o3.if_gnt}, 32'd1);
    chk1("blk_if_addr_after", o3.mem_addr, 32'h300);
    @(negedge clk);
    i3 = '0;

    // Reset one cycle into an IF access (MEM_LAT=3).
    do_reset();
    i3.if_req = 1'b1; i3.if_addr = 32'h10; i3.mem_rdata = 32'h1234_5678;
    #1;
    chk1("mid_rst_gnt", {31'd0, o3.if_gnt}, 32'd1);
    @(negedge clk);
    i3.if_req = 1'b0;
    #1;
    chk1("mid_rst_busy", {31'd0, o3.busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_outputs", o3, '0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    rv_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (o3.if_rvalid || o3.ls_rvalid || o3.busy) rv_cnt++;
      @(negedge clk);
    end
    chk1("mid_rst_no_rvalid", rv_cnt, 0);
    i3.if_req = 1'b1; i3.ls_req = 1'b1;
    #1;
    chk1("mid_rst_tie_if", {31'd0, o3.if_gnt}, 32'd1);
    chk1("mid_rst_tie_ls", {31'd0, o3.ls_gnt}, 32'd0);
    @(negedge clk);
    i3 = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
